// File: rtl/fpu_mds_issue.sv
// Issue side of the FP mul/div/sqrt start/done protocol: accepts a request, unpacks the
// operands, pulses start, then collects done (or times out) and returns the result.
module fpu_mds_issue #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TAG_W          = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [2:0]       req_rm,
    input  logic [31:0]      req_rs1,
    input  logic [31:0]      req_rs2,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             mds_start,
    output logic [1:0]       mds_op,
    output logic [2:0]       mds_rm,
    output logic             sign_A,
    output logic             sign_B,
    output logic [7:0]       exp_A,
    output logic [7:0]       exp_B,
    output logic [23:0]      sig_A,
    output logic [23:0]      sig_B,
    output logic             isZeroA,
    output logic             isZeroB,
    output logic             isInfA,
    output logic             isInfB,
    output logic             isNaNA,
    output logic             isNaNB,
    output logic             isSignaling,
    output logic             subnormal_sqrt_in,
    input  logic [31:0]      mds_result,
    input  logic             mds_done,
    input  logic             mds_of,
    input  logic             mds_uf,
    input  logic             mds_nv,
    input  logic             mds_nx,
    input  logic             mds_dz,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_data,
    output logic [TAG_W-1:0] resp_tag,
    output logic [4:0]       resp_fflags,
    output logic             resp_timeout,
    output logic [4:0]       fflags_acc,
    input  logic             fflags_clr
);
    localparam int          CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_drain_pending;
    logic [1:0]       r_op;
    logic [2:0]       r_rm;
    logic [TAG_W-1:0] r_tag;
    logic             r_is_sig;
    logic             r_sub_sqrt;
    logic [31:0]      r_resp_data;
    logic [4:0]       r_resp_fflags;
    logic             r_resp_timeout;
    logic [4:0]       r_fflags_acc;

    logic [31:0] w_opnd [2];
    logic        w_sign [2];
    logic [7:0]  w_exp  [2];
    logic [23:0] w_sig  [2];
    logic        w_zero [2];
    logic        w_inf  [2];
    logic        w_nan  [2];
    logic        w_snan [2];
    logic        w_sub  [2];
    logic        r_sign [2];
    logic [7:0]  r_exp  [2];
    logic [23:0] r_sig  [2];
    logic        r_zero [2];
    logic        r_inf  [2];
    logic        r_nan  [2];

    logic w_req_fire;
    logic w_illegal;
    logic w_timeout;
    logic w_drain_eff;

    assign w_opnd[0]   = req_rs1;
    assign w_opnd[1]   = req_rs2;
    assign w_req_fire  = req_valid && req_ready;
    assign w_illegal   = (req_op == 2'b11);
    assign w_timeout   = (r_state == S_WAIT) && !mds_done && (r_cnt == CNT_LIMIT);
    // A done seen in the same cycle as leaving RESP already retires the stale operation.
    assign w_drain_eff = r_drain_pending && !mds_done;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            logic [7:0]  w_ef;
            logic [22:0] w_fr;
            assign w_ef       = w_opnd[gi][30:23];
            assign w_fr       = w_opnd[gi][22:0];
            assign w_sign[gi] = w_opnd[gi][31];
            assign w_exp[gi]  = (w_ef == 8'h00) ? 8'h01 : w_ef;
            assign w_sig[gi]  = {(w_ef != 8'h00), w_fr};
            assign w_zero[gi] = (w_ef == 8'h00) && (w_fr == 23'd0);
            assign w_sub[gi]  = (w_ef == 8'h00) && (w_fr != 23'd0);
            assign w_inf[gi]  = (w_ef == 8'hFF) && (w_fr == 23'd0);
            assign w_nan[gi]  = (w_ef == 8'hFF) && (w_fr != 23'd0);
            assign w_snan[gi] = w_nan[gi] && !w_fr[22];

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    r_sign[gi] <= 1'b0;
                    r_exp[gi]  <= 8'd0;
                    r_sig[gi]  <= 24'd0;
                    r_zero[gi] <= 1'b0;
                    r_inf[gi]  <= 1'b0;
                    r_nan[gi]  <= 1'b0;
                end else if (w_req_fire) begin
                    r_sign[gi] <= w_sign[gi];
                    r_exp[gi]  <= w_exp[gi];
                    r_sig[gi]  <= w_sig[gi];
                    r_zero[gi] <= w_zero[gi];
                    r_inf[gi]  <= w_inf[gi];
                    r_nan[gi]  <= w_nan[gi];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_req_fire) w_next = w_illegal ? S_RESP : S_ISSUE;
            S_ISSUE: w_next = flush ? S_DRAIN : S_WAIT;
            S_WAIT: begin
                if (flush)                       w_next = mds_done ? S_IDLE : S_DRAIN;
                else if (mds_done || w_timeout)  w_next = S_RESP;
            end
            S_RESP:  if (flush || resp_ready) w_next = w_drain_eff ? S_DRAIN : S_IDLE;
            S_DRAIN: if (mds_done) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready  = reset && (r_state == S_IDLE) && !flush;
        mds_start  = (r_state == S_ISSUE);
        resp_valid = (r_state == S_RESP);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt           <= '0;
            r_drain_pending <= 1'b0;
            r_op            <= 2'b00;
            r_rm            <= 3'b000;
            r_tag           <= '0;
            r_is_sig        <= 1'b0;
            r_sub_sqrt      <= 1'b0;
            r_resp_data     <= 32'd0;
            r_resp_fflags   <= 5'd0;
            r_resp_timeout  <= 1'b0;
            r_fflags_acc    <= 5'd0;
        end else begin
            if (w_req_fire) begin
                r_op       <= req_op;
                r_rm       <= req_rm;
                r_tag      <= req_tag;
                r_is_sig   <= w_snan[0] || ((req_op != 2'b10) && w_snan[1]);
                r_sub_sqrt <= (req_op == 2'b10) && w_sub[0];
            end

            r_cnt <= (r_state == S_WAIT) ? r_cnt + CNT_W'(1) : '0;

            if (w_req_fire && w_illegal) begin
                r_resp_data    <= QNAN;
                r_resp_fflags  <= 5'b10000;
                r_resp_timeout <= 1'b0;
            end else if ((r_state == S_WAIT) && mds_done) begin
                r_resp_data    <= mds_result;
                r_resp_fflags  <= {mds_nv, mds_dz, mds_of, mds_uf, mds_nx};
                r_resp_timeout <= 1'b0;
            end else if (w_timeout) begin
                r_resp_data    <= QNAN;
                r_resp_fflags  <= 5'b00000;
                r_resp_timeout <= 1'b1;
            end

            // The timed-out operation is still running in the unit; remember to drain it.
            if (w_timeout && !flush)
                r_drain_pending <= 1'b1;
            else if ((r_state == S_RESP) && (mds_done || (w_next != S_RESP)))
                r_drain_pending <= 1'b0;

            if (fflags_clr)
                r_fflags_acc <= 5'd0;
            else if ((r_state == S_RESP) && resp_ready && !flush)
                r_fflags_acc <= r_fflags_acc | r_resp_fflags;
        end
    end

    assign mds_op            = r_op;
    assign mds_rm            = r_rm;
    assign sign_A            = r_sign[0];
    assign sign_B            = r_sign[1];
    assign exp_A             = r_exp[0];
    assign exp_B             = r_exp[1];
    assign sig_A             = r_sig[0];
    assign sig_B             = r_sig[1];
    assign isZeroA           = r_zero[0];
    assign isZeroB           = r_zero[1];
    assign isInfA            = r_inf[0];
    assign isInfB            = r_inf[1];
    assign isNaNA            = r_nan[0];
    assign isNaNB            = r_nan[1];
    assign isSignaling       = r_is_sig;
    assign subnormal_sqrt_in = r_sub_sqrt;
    assign resp_data         = r_resp_data;
    assign resp_tag          = r_tag;
    assign resp_fflags       = r_resp_fflags;
    assign resp_timeout      = r_resp_timeout;
    assign fflags_acc        = r_fflags_acc;
endmodule
